ram_dp_be: RTL and testbench
============================

# ram_dp_be

Parametrised dual-port synchronous RAM: the next generation of the team's 1024×32 single-port data memory. Port A reads/writes with byte enables; port B is read-only. Both ports use a request/valid handshake, and an optional output register stage is available. An optional post-reset clear sequencer zeroes the array before the block reports ready. The block sits between the datapath (port A, load/store) and debug/DMA readers (port B).

## Interface
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 10, address width in bits; DEPTH = 2**ADDR_W words.
- OUT_REG, 0, 0 gives 1-cycle read latency; 1 adds an output register stage, giving 2-cycle latency.
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- ready  out  1  high when requests are accepted.
- a_req  in  1  port A request strobe.
- a_we  in  1  1 = write, 0 = read; sampled with a_req.
- a_be  in  DATA_W/8  byte write enables; bit i covers din[8i+7:8i].
- a_addr  in  ADDR_W  port A word address.
- a_din  in  DATA_W  port A write data.
- a_dout  out  DATA_W  port A read data.
- a_valid  out  1  one-cycle pulse when a_dout carries new read data.
- b_req  in  1  port B read request.
- b_addr  in  ADDR_W  port B word address.
- b_dout  out  DATA_W  port B read data.
- b_valid  out  1  one-cycle pulse when b_dout carries new read data.

## Operation
- A request is accepted when its req is high and ready is high at a rising edge. Requests made while ready is low are dropped: no write, no valid.
- Port A write: for each byte i with a_be[i]=1, the byte is written as RAM[a_addr] byte i = a_din byte i. Bytes with a_be[i]=0 are unchanged. A write with a_be all zero is a no-op. Writes leave a_dout and a_valid unchanged (a_valid stays 0 for writes).
- Port A read and port B read: return the addressed word and pulse the corresponding valid.
- dout holds its last value until the next accepted read on that port.
- Collision (A writes and B reads the same address in the same cycle): B returns the old data (read-first). The new data is visible from the next access.
- Both ports are fully independent. Each port accepts one request per cycle, with no bubbles.
- The memory array is not reset. Only the control state and the outputs are.

## Timing
- Reset values: a_dout=0, b_dout=0, a_valid=0, b_valid=0, output pipeline registers=0.
  - ready=0 with RAM_CLEAR_EN defined.
  - ready=1 without it.
- Read latency, OUT_REG=0: request accepted at edge n; dout and valid are updated at edge n, so they are visible during cycle n+1.
- Read latency, OUT_REG=1: dout and valid are updated at edge n+1.
- In both OUT_REG settings, valid is high for exactly one cycle per accepted read.
- Write latency: data is readable by a request accepted at edge n+1 or later.
- Reset asserted mid-operation:
  - Reads in flight are discarded and valids clear immediately.
  - Array contents are preserved, except for the clear behaviour below.

## Configuration
- RAM_CLEAR_EN defined: a clear sequencer is compiled in.
  - After rst deasserts, states run CLEAR -> READY.
  - In CLEAR, port A's write path writes 0 to address 0, 1, …, DEPTH-1, one word per cycle, so clear takes DEPTH cycles.
  - ready rises on the edge after the write of address DEPTH-1. With DEPTH=1024, ready is first high 1024 cycles after the first post-reset edge.
  - rst asserted during CLEAR restarts the sweep at address 0.
  - READY is absorbing until the next rst.
- RAM_CLEAR_EN undefined: no sequencer. ready is tied to 1 and contents are uninitialised (X in simulation).

## Structure
- Package ram_pkg holds:
  - RAM_DATA_W_DEF=32 and RAM_ADDR_W_DEF=10;
  - enum ram_state_t {RS_CLEAR, RS_READY};
  - function be_merge(old, new, be) for byte-enable merging.
- One sub-module, ram_clear_seq: the FSM plus ADDR_W-bit address counter, and the ready output. It is instantiated only under RAM_CLEAR_EN.
- The top level holds the array, the read ports, and the OUT_REG pipeline via generate.

## Test plan
- Reset then idle, RAM_CLEAR_EN, defaults -> ready low for exactly 1024 cycles; afterwards a read of every address returns 0x00000000.
- Write A addr 5 = 0xDEADBEEF with a_be=4'b1111, then write addr 5 = 0x11223344 with a_be=4'b0101, then read A addr 5 -> 0xDE22BE44 after 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1), with a single a_valid pulse.
- Same cycle: A writes addr 7 = 0xCAFEF00D (old 0x0) while B reads addr 7 -> b_dout=0x00000000. B reads addr 7 on the next cycle -> 0xCAFEF00D.
- Back-to-back B reads of addrs 0..15 on consecutive cycles -> 16 consecutive b_valid pulses with matching data and no gaps, at both OUT_REG values.
- rst pulsed when the clear counter is at 500 -> ready stays low and the sweep restarts at 0. ready rises 1024 cycles after the reset release.
- a_req held high while ready=0 with a write to addr 3 = 0xFFFFFFFF -> ignored. After ready, addr 3 reads 0x00000000 and no a_valid was seen during the clear.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port byte-enable RAM: default geometry,
// clear-sequencer state encoding and the byte-enable merge helper.
package ram_pkg;

   localparam int RAM_DATA_W_DEF = 32;
   localparam int RAM_ADDR_W_DEF = 10;

   // Widest word the merge helper handles; callers zero-extend into it.
   localparam int RAM_MAX_W  = 256;
   localparam int RAM_MAX_BE = RAM_MAX_W / 8;

   typedef enum logic {RS_CLEAR, RS_READY} ram_state_t;

   function automatic logic [RAM_MAX_W-1:0] be_merge(
      input logic [RAM_MAX_W-1:0]  old_w,
      input logic [RAM_MAX_W-1:0]  new_w,
      input logic [RAM_MAX_BE-1:0] be
   );
      logic [RAM_MAX_W-1:0] r;
      r = old_w;
      for (int i = 0; i < RAM_MAX_BE; i++)
         if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
      return r;
   endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sweep: drives zero writes to every address, then raises
// ready one cycle after the final write. Used only when RAM_CLEAR_EN is set.
module ram_clear_seq
   import ram_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              ready
);

   ram_state_t state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= RS_CLEAR;
         clr_addr <= '0;
         ready    <= 1'b0;
      end else begin
         // ready trails the state so it rises on the edge after the last write
         ready <= (state == RS_READY);
         if (state == RS_CLEAR) begin
            clr_addr <= clr_addr + ADDR_W'(1);
            if (clr_addr == '1) state <= RS_READY;
         end
      end
   end

   assign clr_we = (state == RS_CLEAR);

endmodule

// File: rtl/ram_dp_be.sv
// Dual-port RAM: port A read/write with byte enables, port B read-only,
// optional output register (OUT_REG). Define RAM_CLEAR_EN for the zeroing sweep.
module ram_dp_be
   import ram_pkg::*;
#(
   parameter int DATA_W  = RAM_DATA_W_DEF,
   parameter int ADDR_W  = RAM_ADDR_W_DEF,
   parameter int OUT_REG = 0
) (
   input  logic                clk,
   input  logic                rst,
   output logic                ready,
   input  logic                a_req,
   input  logic                a_we,
   input  logic [DATA_W/8-1:0] a_be,
   input  logic [ADDR_W-1:0]   a_addr,
   input  logic [DATA_W-1:0]   a_din,
   output logic [DATA_W-1:0]   a_dout,
   output logic                a_valid,
   input  logic                b_req,
   input  logic [ADDR_W-1:0]   b_addr,
   output logic [DATA_W-1:0]   b_dout,
   output logic                b_valid
);

   localparam int DEPTH  = 2**ADDR_W;
   localparam int NBE    = DATA_W / 8;
   localparam int STAGES = OUT_REG;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              a_acc;
   logic              w_en;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_data;
   logic [NBE-1:0]    w_be;

   assign a_acc = a_req & ready;

`ifdef RAM_CLEAR_EN
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;

   ram_clear_seq #(.ADDR_W(ADDR_W)) u_clr (
      .clk      (clk),
      .rst      (rst),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .ready    (ready)
   );

   // The sweep borrows port A's write path; ready is low so A cannot collide.
   assign w_en   = clr_we | (a_acc & a_we);
   assign w_addr = clr_we ? clr_addr : a_addr;
   assign w_data = clr_we ? '0 : a_din;
   assign w_be   = clr_we ? '1 : a_be;
`else
   assign ready  = 1'b1;
   assign w_en   = a_acc & a_we;
   assign w_addr = a_addr;
   assign w_data = a_din;
   assign w_be   = a_be;
`endif

   always_ff @(posedge clk)
      if (w_en)
         mem[w_addr] <= DATA_W'(be_merge(RAM_MAX_W'(mem[w_addr]),
                                         RAM_MAX_W'(w_data),
                                         RAM_MAX_BE'(w_be)));

   logic [1:0]             rd;
   logic [1:0][ADDR_W-1:0] raddr;
   logic [1:0]             vld;
   logic [1:0][DATA_W-1:0] rdat;

   assign rd    = {b_req & ready, a_acc & ~a_we};
   assign raddr = {b_addr, a_addr};

   // Port index 0 = A, 1 = B. Reads sample the array before same-edge
   // writes land, which gives B read-first behaviour on collisions.
   for (genvar p = 0; p < 2; p++) begin : g_port
      logic [STAGES:0]             vld_pipe;
      logic [STAGES:0][DATA_W-1:0] dat_pipe;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
         end else begin
            vld_pipe[0] <= rd[p];
            if (rd[p]) dat_pipe[0] <= mem[raddr[p]];
            for (int s = 1; s <= STAGES; s++) begin
               vld_pipe[s] <= vld_pipe[s-1];
               if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
            end
         end
      end

      assign vld[p]  = vld_pipe[STAGES];
      assign rdat[p] = dat_pipe[STAGES];
   end

   assign a_valid = vld[0];
   assign a_dout  = rdat[0];
   assign b_valid = vld[1];
   assign b_dout  = rdat[1];

endmodule

// File: tb/tb_ram_dp_be.sv
// Bench for ram_dp_be: two instances (OUT_REG=0 and 1) on shared stimulus,
// a reference memory and per-port scoreboards stamped with the expected cycle.
module tb_ram_dp_be;

   localparam int DW    = 32;
   localparam int AW    = 10;
   localparam int DEPTH = 1024;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0;
   logic [3:0]    a_be = '0;
   logic [AW-1:0] a_addr = '0, b_addr = '0;
   logic [DW-1:0] a_din = '0;

   logic [1:0]         ready, a_valid, b_valid;
   logic [1:0][DW-1:0] a_dout, b_dout;

   ram_dp_be #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(0)) dut0 (
      .clk(clk), .rst(rst), .ready(ready[0]),
      .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
      .a_dout(a_dout[0]), .a_valid(a_valid[0]),
      .b_req(b_req), .b_addr(b_addr), .b_dout(b_dout[0]), .b_valid(b_valid[0])
   );

   ram_dp_be #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(1)) dut1 (
      .clk(clk), .rst(rst), .ready(ready[1]),
      .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
      .a_dout(a_dout[1]), .a_valid(a_valid[1]),
      .b_req(b_req), .b_addr(b_addr), .b_dout(b_dout[1]), .b_valid(b_valid[1])
   );

   typedef struct {
      logic [DW-1:0] d;
      int            c;
   } exp_t;

   // Queue index: 0 = A/dut0, 1 = B/dut0, 2 = A/dut1, 3 = B/dut1
   exp_t          sq [4][$];
   logic [DW-1:0] model [DEPTH];
   bit            ready_m = 1'b0;
   int            cyc = 0;
   int            checks = 0, passed = 0;

`ifdef RAM_CLEAR_EN
   localparam bit READY_RST = 1'b0;
`else
   localparam bit READY_RST = 1'b1;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #900000;
      $display("FAIL timeout: bench did not reach its end, got running exp finished");
      $fatal(1);
   end

   always @(negedge clk) begin
      logic [3:0]         v;
      logic [3:0][DW-1:0] d;
      exp_t               e;
      v = {b_valid[1], a_valid[1], b_valid[0], a_valid[0]};
      d = {b_dout[1], a_dout[1], b_dout[0], a_dout[0]};
      for (int p = 0; p < 4; p++) begin
         if (v[p]) begin
            checks++;
            if (sq[p].size() == 0) begin
               $display("FAIL valid_q%0d: got unexpected valid data %h @%0d exp none", p, d[p], cyc);
            end else begin
               e = sq[p].pop_front();
               if (d[p] !== e.d || cyc != e.c)
                  $display("FAIL read_q%0d: got %h @%0d exp %h @%0d", p, d[p], cyc, e.d, e.c);
               else
                  passed++;
            end
         end
      end
   end

   // One request cycle; called just after a rising edge.
   task automatic drive(input bit ar, input bit aw, input logic [3:0] be,
                        input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input bit br, input logic [AW-1:0] ba);
      a_req = ar; a_we = aw; a_be = be; a_addr = aa; a_din = ad;
      b_req = br; b_addr = ba;
      if (ready_m) begin
         for (int l = 0; l < 2; l++) begin
            if (br)        sq[2*l+1].push_back('{model[ba], cyc + 1 + l});
            if (ar && !aw) sq[2*l].push_back('{model[aa], cyc + 1 + l});
         end
         if (ar && aw)
            for (int i = 0; i < 4; i++)
               if (be[i]) model[aa][8*i +: 8] = ad[8*i +: 8];
      end
      @(posedge clk); #1;
      a_req = 1'b0; b_req = 1'b0;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (ready[k] !== READY_RST) $display("FAIL rst_ready%0d: got %b exp %b", k, ready[k], READY_RST);
         else passed++;
         checks++;
         if (a_valid[k] !== 1'b0 || b_valid[k] !== 1'b0)
            $display("FAIL rst_valid%0d: got %b%b exp 00", k, a_valid[k], b_valid[k]);
         else passed++;
         checks++;
         if (a_dout[k] !== '0 || b_dout[k] !== '0)
            $display("FAIL rst_dout%0d: got %h/%h exp 0", k, a_dout[k], b_dout[k]);
         else passed++;
      end
   endtask

`ifdef RAM_CLEAR_EN
   // Counts edges from reset release (done by caller) until ready is seen.
   task automatic wait_ready(input string tag);
      int n0, n1;
      n0 = 0; n1 = 0;
      for (int n = 1; n <= 1100; n++) begin
         @(posedge clk); #1;
         if (ready[0] && n0 == 0) n0 = n;
         if (ready[1] && n1 == 0) n1 = n;
         if (n0 != 0 && n1 != 0) break;
      end
      a_req = 1'b0;
      checks++;
      if (n0 != 1025) $display("FAIL %s_dut0: got ready at edge %0d exp 1025", tag, n0);
      else passed++;
      checks++;
      if (n1 != 1025) $display("FAIL %s_dut1: got ready at edge %0d exp 1025", tag, n1);
      else passed++;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      ready_m = 1'b1;
   endtask

   task automatic test_clear();
      // A write held during the sweep must be dropped.
      a_req = 1'b1; a_we = 1'b1; a_be = 4'hF; a_addr = 10'd3; a_din = 32'hFFFF_FFFF;
      rst = 1'b0;
      wait_ready("clear");
   endtask

   task automatic test_clear_restart();
      ready_m = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (500) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      checks++;
      if (ready !== 2'b00) $display("FAIL restart_ready: got %b exp 00", ready);
      else passed++;
      @(posedge clk); #1;
      rst = 1'b0;
      wait_ready("restart");
   endtask

   task automatic test_clear_sweep();
      for (int i = 0; i < DEPTH; i++)
         drive(1'b1, 1'b0, 4'h0, AW'(i), '0, 1'b1, AW'(DEPTH - 1 - i));
      repeat (3) begin @(posedge clk); #1; end
   endtask
`endif

   task automatic test_byte_enable();
      drive(1'b1, 1'b1, 4'b1111, 10'd5, 32'hDEAD_BEEF, 1'b0, '0);
      drive(1'b1, 1'b1, 4'b0101, 10'd5, 32'h1122_3344, 1'b0, '0);
      drive(1'b1, 1'b0, 4'b0000, 10'd5, '0, 1'b0, '0);
      drive(1'b1, 1'b1, 4'b0000, 10'd5, 32'h5555_5555, 1'b0, '0);
      drive(1'b1, 1'b0, 4'b0000, 10'd5, '0, 1'b1, 10'd5);
      repeat (3) begin @(posedge clk); #1; end
   endtask

   task automatic test_collision();
      drive(1'b1, 1'b1, 4'hF, 10'd7, 32'h0, 1'b0, '0);
      drive(1'b1, 1'b1, 4'hF, 10'd7, 32'hCAFE_F00D, 1'b1, 10'd7);
      drive(1'b0, 1'b0, 4'h0, '0, '0, 1'b1, 10'd7);
      repeat (3) begin @(posedge clk); #1; end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++)
         drive(1'b1, 1'b1, 4'hF, AW'(i), 32'hA5A5_A5A5 ^ (32'h0101_0101 * i), 1'b0, '0);
      for (int i = 0; i < 16; i++)
         drive(1'b1, 1'b0, 4'h0, AW'(15 - i), '0, 1'b1, AW'(i));
      repeat (3) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset_midop();
      ready_m = 1'b0;
      drive(1'b1, 1'b0, 4'h0, 10'd5, '0, 1'b1, 10'd7);
      checks++;
      if (a_valid[0] !== 1'b1 || b_valid[0] !== 1'b1)
         $display("FAIL midop_pre: got %b%b exp 11", a_valid[0], b_valid[0]);
      else passed++;
      rst = 1'b1;
      #1;
      checks++;
      if (a_valid !== 2'b00 || b_valid !== 2'b00)
         $display("FAIL midop_valid: got %b/%b exp 00/00", a_valid, b_valid);
      else passed++;
      checks++;
      if (a_dout !== '0 || b_dout !== '0)
         $display("FAIL midop_dout: got %h/%h exp 0", a_dout, b_dout);
      else passed++;
      @(posedge clk); #1;
      rst = 1'b0;
`ifdef RAM_CLEAR_EN
      wait_ready("midop");
`else
      ready_m = 1'b1;
`endif
      drive(1'b1, 1'b0, 4'h0, 10'd5, '0, 1'b1, 10'd7);
      drive(1'b0, 1'b0, 4'h0, '0, '0, 1'b1, 10'd15);
      repeat (3) begin @(posedge clk); #1; end
   endtask

   initial begin
      repeat (2) begin @(posedge clk); #1; end
      test_reset();
`ifdef RAM_CLEAR_EN
      test_clear();
      test_clear_sweep();
      test_clear_restart();
`else
      rst = 1'b0;
      ready_m = 1'b1;
      @(posedge clk); #1;
`endif
      test_byte_enable();
      test_collision();
      test_back_to_back();
      test_reset_midop();
      repeat (4) begin @(posedge clk); #1; end
      for (int p = 0; p < 4; p++) begin
         checks++;
         if (sq[p].size() != 0) $display("FAIL drain_q%0d: got %0d pending exp 0", p, sq[p].size());
         else passed++;
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
